hpdcache_req_arbiter: RTL and testbench
=======================================

Name: hpdcache_req_arbiter

Overview:
Round-robin arbiter that shares one HPDcache core requester port between NREQ upstream requesters (e.g. load unit, store unit, PTW, prefetcher). It tags each granted request with the requester index in the upper TID bits and forwards that requester's late tag/abort/PMA in the cycle after the grant. It demultiplexes responses back by TID and caps outstanding responses per requester.

Parameters:
NREQ, 4, number of upstream requesters (1..16)
TID_W, 6, width of hpdcache_req_tid_t
MAX_OUTSTANDING, 4, max responses pending per requester (1..15)
hpdcache_req_t, -, core request type (fields: tid, need_rsp)
hpdcache_rsp_t, -, core response type (field: tid)
hpdcache_tag_t, -, physical tag type
IDX_W, derived, $clog2(NREQ), 0 when NREQ=1

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
core_req_valid_i  in  [NREQ]  upstream request valid
core_req_ready_o  out  [NREQ]  upstream request ready
core_req_i  in  [NREQ] x hpdcache_req_t  upstream request
core_req_abort_i  in  [NREQ]  late abort, cycle after handshake
core_req_tag_i  in  [NREQ] x hpdcache_tag_t  late tag
core_req_pma_i  in  [NREQ] x hpdcache_pma_t  late PMA
core_rsp_valid_o  out  [NREQ]  response valid to requester
core_rsp_o  out  [NREQ] x hpdcache_rsp_t  response to requester
cache_req_valid_o  out  1  request valid to cache
cache_req_ready_i  in  1  cache ready
cache_req_o  out  hpdcache_req_t  request to cache, TID rewritten
cache_req_abort_o  out  1  late abort to cache
cache_req_tag_o  out  hpdcache_tag_t  late tag to cache
cache_req_pma_o  out  hpdcache_pma_t  late PMA to cache
cache_rsp_valid_i  in  1  cache response valid
cache_rsp_i  in  hpdcache_rsp_t  cache response
err_o  out  1  sticky protocol error

Behaviour:
- Eligible(i) = core_req_valid_i[i] && (!core_req_i[i].need_rsp || cnt[i] < MAX_OUTSTANDING).
- Grant: combinational round-robin over eligible, starting at ptr. cache_req_valid_o = any eligible. core_req_ready_o[i] = (gnt==i) && cache_req_ready_i. No ready-to-valid combinational path toward the cache.
- ptr advances to gnt+1 mod NREQ only on handshake (cache_req_valid_o && cache_req_ready_i). On stall, ptr and the grant are held. An upstream valid must stay asserted until ready.
- cache_req_o = granted request, with tid[TID_W-1 -: IDX_W] = gnt. Upstream TIDs must have the top IDX_W bits zero. A nonzero top bit on an upstream handshake sets err_o.
- Stage-1 register: on handshake, s1_valid<=1, s1_idx<=gnt, s1_need<=need_rsp. Otherwise s1_valid<=0.
- Late outputs, 1 cycle after handshake:
  - cache_req_abort_o = s1_valid && core_req_abort_i[s1_idx].
  - tag and PMA are muxed by s1_idx.
  - When !s1_valid, abort=0 and tag/PMA=0.
- Response path (zero latency):
  - idx = cache_rsp_i.tid upper IDX_W bits.
  - core_rsp_valid_o[idx] = cache_rsp_valid_i. All other valids are 0.
  - core_rsp_o[*] = cache_rsp_i with the upper IDX_W TID bits cleared.
  - idx >= NREQ sets err_o and drops the response.
- Counter cnt[i] (4 bits):
  - +1 on handshake granted to i with need_rsp.
  - -1 on response to i.
  - -1 when s1 aborts with s1_idx==i and s1_need, since aborted requests receive no response.
  - All three events may coincide in one cycle; the net update is applied in that cycle.
  - A response to i with cnt[i]==0 sets err_o; cnt stays at 0.
- Full: cnt[i]==MAX_OUTSTANDING masks i only for need_rsp requests. Requests without need_rsp still arbitrate.
- NREQ=1: pure passthrough with counter; no TID rewrite.
- Reset (including mid-transaction): ptr=0, s1_valid=0, cnt=0, err_o=0.
  - All ready and valid outputs are 0 in the reset cycle.
  - Any in-flight response arriving after reset is routed normally but sets err_o via the cnt==0 rule.

Test Plan:
- Four requesters valid continuously, cache_req_ready_i=1, need_rsp=1, MAX_OUTSTANDING large → grants 0,1,2,3,0; cache_req_o.tid upper 2 bits match the grant index.
- Requester 2 handshake at cycle t with core_req_abort_i[2]=1 at t+1 → cache_req_abort_o=1 at t+1 only; cnt[2] returns to its pre-request value at t+2.
- Requester 1 issues 4 need_rsp requests with no responses (MAX=4) → 5th request is not granted; a response with tid=6'b01_0011 releases it; core_rsp_o[1].tid=6'b00_0011.
- cache_req_ready_i=0 for 3 cycles with requesters 0 and 3 valid → grant holds on 0 and ptr is unchanged; after ready rises, grant order is 0 then 3.
- Same cycle: response to requester 0, new need_rsp grant to 0, and s1 abort for 0, starting from cnt[0]=2 → cnt[0]=1 next cycle.
- Response with tid upper bits = 2 while cnt[2]=0 → err_o=1 and stays 1; rst_i pulse → err_o=0, cnt=0, ptr=0.

Source files
------------

// File: rtl/hpdcache_req_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one HPDcache core port.
// Grants are tagged with the requester index in the top TID bits, and responses are routed back by that tag.
package hpdcache_req_arbiter_pkg;
    localparam int unsigned TID_W = 6;
    typedef logic [TID_W-1:0] hpdcache_req_tid_t;
    typedef struct packed {
        logic [7:0]        wdata;
        logic              need_rsp;
        hpdcache_req_tid_t tid;
    } hpdcache_req_t;
    typedef struct packed {
        logic [7:0]        rdata;
        hpdcache_req_tid_t tid;
    } hpdcache_rsp_t;
    typedef logic [11:0] hpdcache_tag_t;
    typedef struct packed {
        logic uncacheable;
        logic io;
    } hpdcache_pma_t;
endpackage

module hpdcache_req_arbiter #(
    parameter int unsigned NREQ            = 4,
    parameter int unsigned TID_W           = 6,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter type hpdcache_req_t = hpdcache_req_arbiter_pkg::hpdcache_req_t,
    parameter type hpdcache_rsp_t = hpdcache_req_arbiter_pkg::hpdcache_rsp_t,
    parameter type hpdcache_tag_t = hpdcache_req_arbiter_pkg::hpdcache_tag_t,
    parameter type hpdcache_pma_t = hpdcache_req_arbiter_pkg::hpdcache_pma_t
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      core_req_valid_i,
    output logic [NREQ-1:0]      core_req_ready_o,
    input  hpdcache_req_t        core_req_i       [NREQ],
    input  logic [NREQ-1:0]      core_req_abort_i,
    input  hpdcache_tag_t        core_req_tag_i   [NREQ],
    input  hpdcache_pma_t        core_req_pma_i   [NREQ],
    output logic [NREQ-1:0]      core_rsp_valid_o,
    output hpdcache_rsp_t        core_rsp_o       [NREQ],
    output logic                 cache_req_valid_o,
    input  logic                 cache_req_ready_i,
    output hpdcache_req_t        cache_req_o,
    output logic                 cache_req_abort_o,
    output hpdcache_tag_t        cache_req_tag_o,
    output hpdcache_pma_t        cache_req_pma_o,
    input  logic                 cache_rsp_valid_i,
    input  hpdcache_rsp_t        cache_rsp_i,
    output logic                 err_o
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 0;
    localparam int unsigned IW    = (IDX_W > 0) ? IDX_W : 1;
    typedef logic [IW-1:0] idx_t;

    idx_t          ptr_q, ptr_d;
    idx_t          gnt, cand;
    logic          any_elig;
    logic [NREQ-1:0] elig;
    logic          hs;
    logic          s1_valid_q, s1_need_q;
    idx_t          s1_idx_q;
    logic [3:0]    cnt_q [NREQ];
    logic [3:0]    cnt_d [NREQ];
    logic          err_q, err_d;
    idx_t          rsp_idx;
    logic          rsp_in_range;
    logic          tid_hi_bad;
    hpdcache_rsp_t rsp_clr;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            elig[i] = core_req_valid_i[i] &&
                      (!core_req_i[i].need_rsp || (cnt_q[i] < 4'(MAX_OUTSTANDING)));
        end
    end

    // Scan requesters starting from ptr_q; the first eligible one wins.
    always_comb begin
        gnt      = '0;
        cand     = '0;
        any_elig = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = idx_t'((32'(ptr_q) + k) % NREQ);
            if (!any_elig && elig[cand]) begin
                any_elig = 1'b1;
                gnt      = cand;
            end
        end
    end

    assign cache_req_valid_o = any_elig && !rst_i;
    assign hs                = cache_req_valid_o && cache_req_ready_i;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            core_req_ready_o[i] = cache_req_valid_o && cache_req_ready_i && (gnt == idx_t'(i));
        end
    end

    generate
        if (NREQ > 1) begin : g_multi
            always_comb begin
                cache_req_o = core_req_i[gnt];
                cache_req_o.tid[TID_W-1 -: IDX_W] = gnt;
            end
            always_comb begin
                rsp_clr = cache_rsp_i;
                rsp_clr.tid[TID_W-1 -: IDX_W] = '0;
            end
            assign rsp_idx    = cache_rsp_i.tid[TID_W-1 -: IDX_W];
            assign tid_hi_bad = |core_req_i[gnt].tid[TID_W-1 -: IDX_W];
        end else begin : g_single
            assign cache_req_o = core_req_i[0];
            assign rsp_clr     = cache_rsp_i;
            assign rsp_idx     = '0;
            assign tid_hi_bad  = 1'b0;
        end
    endgenerate

    assign rsp_in_range = (32'(rsp_idx) < NREQ);

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            core_rsp_valid_o[i] = !rst_i && cache_rsp_valid_i && rsp_in_range &&
                                  (rsp_idx == idx_t'(i));
            core_rsp_o[i]       = rsp_clr;
        end
    end

    // Late signals belong to the request handshaken in the previous cycle.
    assign cache_req_abort_o = !rst_i && s1_valid_q && core_req_abort_i[s1_idx_q];
    assign cache_req_tag_o   = s1_valid_q ? core_req_tag_i[s1_idx_q] : '0;
    assign cache_req_pma_o   = s1_valid_q ? core_req_pma_i[s1_idx_q] : '0;

    assign ptr_d = !hs ? ptr_q :
                   (32'(gnt) == NREQ - 1) ? '0 : idx_t'(32'(gnt) + 1);

    always_comb begin
        err_d = err_q;
        if (hs && tid_hi_bad) err_d = 1'b1;
        if (!rst_i && cache_rsp_valid_i && !rsp_in_range) err_d = 1'b1;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (hs && (gnt == idx_t'(i)) && core_req_i[gnt].need_rsp) begin
                cnt_d[i] = cnt_d[i] + 4'd1;
            end
            if (core_rsp_valid_o[i]) begin
                if (cnt_q[i] == 4'd0) err_d = 1'b1;
                else                  cnt_d[i] = cnt_d[i] - 4'd1;
            end
            // An aborted request never gets a response, so release its slot.
            if (cache_req_abort_o && (s1_idx_q == idx_t'(i)) && s1_need_q && (cnt_d[i] != 4'd0)) begin
                cnt_d[i] = cnt_d[i] - 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            s1_need_q  <= 1'b0;
            err_q      <= 1'b0;
            for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= '0;
        end else begin
            ptr_q      <= ptr_d;
            s1_valid_q <= hs;
            s1_idx_q   <= gnt;
            s1_need_q  <= core_req_i[gnt].need_rsp;
            err_q      <= err_d;
            for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_hpdcache_req_arbiter.sv
// Directed bench for hpdcache_req_arbiter with grant and response scoreboards.
module tb_hpdcache_req_arbiter;
    import hpdcache_req_arbiter_pkg::*;

    localparam int unsigned NREQ = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NREQ-1:0] req_valid, req_ready, req_abort, rsp_valid;
    hpdcache_req_t   req  [NREQ];
    hpdcache_tag_t   tag  [NREQ];
    hpdcache_pma_t   pma  [NREQ];
    hpdcache_rsp_t   rsp  [NREQ];
    logic            c_valid, c_ready, c_abort, crsp_valid, err;
    hpdcache_req_t   c_req;
    hpdcache_tag_t   c_tag;
    hpdcache_pma_t   c_pma;
    hpdcache_rsp_t   crsp;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int           idx;
        logic [5:0]   tid;
        logic [7:0]   data;
    } rsp_exp_t;
    int       exp_gnt_q [$];
    rsp_exp_t rsp_q [$];

    hpdcache_req_arbiter #(.NREQ(NREQ), .TID_W(6), .MAX_OUTSTANDING(4)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .core_req_valid_i (req_valid),
        .core_req_ready_o (req_ready),
        .core_req_i       (req),
        .core_req_abort_i (req_abort),
        .core_req_tag_i   (tag),
        .core_req_pma_i   (pma),
        .core_rsp_valid_o (rsp_valid),
        .core_rsp_o       (rsp),
        .cache_req_valid_o(c_valid),
        .cache_req_ready_i(c_ready),
        .cache_req_o      (c_req),
        .cache_req_abort_o(c_abort),
        .cache_req_tag_o  (c_tag),
        .cache_req_pma_o  (c_pma),
        .cache_rsp_valid_i(crsp_valid),
        .cache_rsp_i      (crsp),
        .err_o            (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid  = '0;
        req_abort  = '0;
        crsp_valid = 1'b0;
        crsp       = '0;
        c_ready    = 1'b1;
    endtask

    task automatic set_req(input int i, input logic v, input logic need, input logic [5:0] tid);
        req_valid[i]    = v;
        req[i].need_rsp = need;
        req[i].tid      = tid;
        req[i].wdata    = 8'(160 + i);
    endtask

    task automatic check_grant(input string name);
        int g;
        if (exp_gnt_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed empty grant scoreboard expected entry", name);
            return;
        end
        g = exp_gnt_q.pop_front();
        chk({name, ".ready"},  32'(req_ready),     32'(1 << g));
        chk({name, ".tid_hi"}, 32'(c_req.tid[5:4]), 32'(g));
        chk({name, ".data"},   32'(c_req.wdata),    32'(160 + g));
    endtask

    task automatic send_rsp(input int idx, input logic [3:0] lo, input logic [7:0] data);
        rsp_exp_t e;
        logic [1:0] hi;
        hi         = 2'(idx);
        crsp_valid = 1'b1;
        crsp.tid   = {hi, lo};
        crsp.rdata = data;
        e.idx  = idx;
        e.tid  = {2'b00, lo};
        e.data = data;
        rsp_q.push_back(e);
    endtask

    task automatic check_rsp(input string name);
        rsp_exp_t e;
        if (rsp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed empty response scoreboard expected entry", name);
            return;
        end
        e = rsp_q.pop_front();
        chk({name, ".valid"}, 32'(rsp_valid),        32'(1 << e.idx));
        chk({name, ".tid"},   32'(rsp[e.idx].tid),   32'(e.tid));
        chk({name, ".data"},  32'(rsp[e.idx].rdata), 32'(e.data));
    endtask

    initial begin
        idle();
        for (int i = 0; i < int'(NREQ); i++) begin
            set_req(i, 1'b1, 1'b1, 6'h00);
            tag[i] = 12'(16 * i + 1);
            pma[i] = '0;
        end
        tag[2] = 12'h2AB;
        pma[2] = 2'b10;

        // Outputs held low while reset is asserted.
        #1;
        chk("reset.valid", 32'(c_valid), 0);
        chk("reset.ready", 32'(req_ready), 0);
        cyc();
        chk("reset_cycle.valid", 32'(c_valid), 0);
        chk("reset_cycle.ready", 32'(req_ready), 0);
        rst = 1'b0;
        idle();
        cyc();
        chk("post_reset.err", 32'(err), 0);
        chk("post_reset.cnt0", 32'(dut.cnt_q[0]), 0);
        chk("post_reset.cnt3", 32'(dut.cnt_q[3]), 0);
        chk("post_reset.valid", 32'(c_valid), 0);

        // Round robin over four continuously valid requesters.
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b1, 6'(i + 1));
        exp_gnt_q.push_back(0); exp_gnt_q.push_back(1); exp_gnt_q.push_back(2);
        exp_gnt_q.push_back(3); exp_gnt_q.push_back(0);
        for (int k = 0; k < 5; k++) begin
            #1;
            check_grant("rr");
            chk("rr.tid_lo", 32'(c_req.tid[3:0]), 32'(((k % 4) + 1)));
            cyc();
        end
        idle();
        #1;
        chk("rr.cnt0", 32'(dut.cnt_q[0]), 2);
        chk("rr.cnt1", 32'(dut.cnt_q[1]), 1);
        chk("rr.cnt3", 32'(dut.cnt_q[3]), 1);
        send_rsp(0, 4'h1, 8'h10); #1; check_rsp("rsp0a"); cyc();
        send_rsp(0, 4'h1, 8'h11); #1; check_rsp("rsp0b"); cyc();
        send_rsp(1, 4'h2, 8'h12); #1; check_rsp("rsp1");  cyc();
        send_rsp(2, 4'h3, 8'h13); #1; check_rsp("rsp2");  cyc();
        send_rsp(3, 4'h4, 8'h14); #1; check_rsp("rsp3");  cyc();
        idle();
        #1;
        chk("drain.cnt0", 32'(dut.cnt_q[0]), 0);
        chk("drain.cnt2", 32'(dut.cnt_q[2]), 0);
        chk("drain.err", 32'(err), 0);

        // Late abort, tag and PMA follow the handshake by one cycle.
        set_req(2, 1'b1, 1'b1, 6'h05);
        exp_gnt_q.push_back(2);
        #1; check_grant("abort.req");
        cyc();
        req_valid[2] = 1'b0;
        req_abort[2] = 1'b1;
        #1;
        chk("abort.t1.abort", 32'(c_abort), 1);
        chk("abort.t1.tag", 32'(c_tag), 32'h2AB);
        chk("abort.t1.pma", 32'(c_pma), 2);
        chk("abort.t1.cnt2", 32'(dut.cnt_q[2]), 1);
        cyc();
        chk("abort.t2.abort", 32'(c_abort), 0);
        chk("abort.t2.tag", 32'(c_tag), 0);
        chk("abort.t2.cnt2", 32'(dut.cnt_q[2]), 0);
        idle();

        // Outstanding cap on requester 1.
        set_req(1, 1'b1, 1'b1, 6'h03);
        for (int k = 0; k < 4; k++) begin
            exp_gnt_q.push_back(1);
            #1; check_grant("cap.fill");
            cyc();
        end
        #1;
        chk("cap.full.valid", 32'(c_valid), 0);
        chk("cap.full.ready", 32'(req_ready), 0);
        chk("cap.full.cnt1", 32'(dut.cnt_q[1]), 4);
        req[1].need_rsp = 1'b0;
        exp_gnt_q.push_back(1);
        #1; check_grant("cap.noneed");
        cyc();
        req[1].need_rsp = 1'b1;
        send_rsp(1, 4'h3, 8'h5A);
        #1;
        chk("cap.blocked.valid", 32'(c_valid), 0);
        check_rsp("cap.release_rsp");
        cyc();
        crsp_valid = 1'b0;
        exp_gnt_q.push_back(1);
        #1;
        chk("cap.release.cnt1", 32'(dut.cnt_q[1]), 3);
        check_grant("cap.release");
        cyc();
        req_valid[1] = 1'b0;
        #1;
        chk("cap.refill.cnt1", 32'(dut.cnt_q[1]), 4);
        for (int k = 0; k < 4; k++) begin
            send_rsp(1, 4'(k), 8'(k + 32));
            #1; check_rsp("cap.drain");
            cyc();
        end
        idle();
        #1;
        chk("cap.drained.cnt1", 32'(dut.cnt_q[1]), 0);

        // Stall holds the grant and the pointer.
        set_req(3, 1'b1, 1'b0, 6'h07);
        exp_gnt_q.push_back(3);
        #1; check_grant("stall.prep");
        cyc();
        c_ready = 1'b0;
        set_req(0, 1'b1, 1'b0, 6'h01);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall.valid", 32'(c_valid), 1);
            chk("stall.ready", 32'(req_ready), 0);
            chk("stall.tid_hi", 32'(c_req.tid[5:4]), 0);
            chk("stall.ptr", 32'(dut.ptr_q), 0);
            cyc();
        end
        c_ready = 1'b1;
        exp_gnt_q.push_back(0);
        #1; check_grant("stall.g0");
        cyc();
        exp_gnt_q.push_back(3);
        #1; check_grant("stall.g3");
        cyc();
        idle();

        // Response, new grant and abort to requester 0 in one cycle.
        set_req(0, 1'b1, 1'b1, 6'h02);
        exp_gnt_q.push_back(0);
        #1; check_grant("net.a");
        cyc();
        exp_gnt_q.push_back(0);
        #1; check_grant("net.b");
        cyc();
        req_abort[0] = 1'b1;
        send_rsp(0, 4'h5, 8'h77);
        exp_gnt_q.push_back(0);
        #1;
        chk("net.pre.cnt0", 32'(dut.cnt_q[0]), 2);
        chk("net.abort", 32'(c_abort), 1);
        check_grant("net.c");
        check_rsp("net.rsp");
        cyc();
        idle();
        #1;
        chk("net.post.cnt0", 32'(dut.cnt_q[0]), 1);
        chk("net.post.abort", 32'(c_abort), 0);
        send_rsp(0, 4'h6, 8'h78); #1; check_rsp("net.drain"); cyc();
        idle();
        #1;
        chk("net.drained.cnt0", 32'(dut.cnt_q[0]), 0);

        // Response to an idle requester sets the sticky error.
        send_rsp(2, 4'h0, 8'h11);
        #1;
        check_rsp("err.rsp");
        chk("err.before", 32'(err), 0);
        cyc();
        crsp_valid = 1'b0;
        #1;
        chk("err.set", 32'(err), 1);
        chk("err.cnt2", 32'(dut.cnt_q[2]), 0);
        cyc();
        chk("err.sticky", 32'(err), 1);

        rst = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b1, 6'h00);
        #1;
        chk("rst2.valid", 32'(c_valid), 0);
        chk("rst2.ready", 32'(req_ready), 0);
        cyc();
        rst = 1'b0;
        exp_gnt_q.push_back(0);
        #1;
        chk("rst2.err", 32'(err), 0);
        chk("rst2.cnt0", 32'(dut.cnt_q[0]), 0);
        chk("rst2.cnt2", 32'(dut.cnt_q[2]), 0);
        check_grant("rst2.ptr0");
        cyc();
        idle();

        // Nonzero upstream TID top bits are a protocol error.
        set_req(1, 1'b1, 1'b0, 6'h10);
        exp_gnt_q.push_back(1);
        #1;
        check_grant("tid_err.req");
        chk("tid_err.before", 32'(err), 0);
        cyc();
        idle();
        #1;
        chk("tid_err.set", 32'(err), 1);

        chk("sb.gnt_empty", 32'(exp_gnt_q.size()), 0);
        chk("sb.rsp_empty", 32'(rsp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
